// File: rtl/ram_test_pkg.sv
// Shared constants, FSM states and expected-pattern helper for the
// 32x8 test RAM write driver and read-back checker.
package ram_test_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

   function automatic logic [DATA_W-1:0] exp_word(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] seed
   );
      return DATA_W'(addr) + seed;
   endfunction

endpackage

// File: rtl/ram_readback_checker_if.sv
// RAM read port: address/enable out to the RAM, registered q back.
interface ram_readback_checker_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);

   logic [ADDR_W-1:0] address;
   logic              rden;
   logic [DATA_W-1:0] rddata;

   modport master (
      output address,
      output rden,
      input  rddata
   );

   modport slave (
      input  address,
      input  rden,
      output rddata
   );

endinterface

// File: rtl/ram_rd_align.sv
// Delays {valid, address} by the RAM read latency so each issued
// address meets its returned data at the compare.
module ram_rd_align #(
   parameter int ADDR_W     = 5,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr
);

   logic [RD_LATENCY-1:0] r_vld;
   logic [ADDR_W-1:0]     r_adr [RD_LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            r_adr[i] <= '0;
         end
      end else begin
         r_vld[0] <= i_valid;
         r_adr[0] <= i_addr;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_adr[i] <= r_adr[i-1];
         end
      end
   end

   assign o_valid = r_vld[RD_LATENCY-1];
   assign o_addr  = r_adr[RD_LATENCY-1];

endmodule

// File: rtl/ram_readback_checker.sv
// Sweeps every RAM address once, compares q against the seeded counter
// pattern and reports verdict, error count and first failing location.
module ram_readback_checker #(
   parameter int ADDR_W     = ram_test_pkg::ADDR_W,
   parameter int DATA_W     = ram_test_pkg::DATA_W,
   parameter int RD_LATENCY = 1
) (
   input  logic                clk_50M,
   input  logic                RST_N,
   input  logic                start,
   input  logic [DATA_W-1:0]   seed,
   ram_readback_checker_if.master ram,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ADDR_W:0]     err_cnt,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic [DATA_W-1:0]   first_err_data
);

   import ram_test_pkg::*;

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] ERR_MAX = '1;

   state_t            r_state;
   state_t            w_state_n;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_n;
   logic [2:0]        r_drain;
   logic [2:0]        w_drain_n;
   logic [DATA_W-1:0] r_seed;
   logic [CW-1:0]     r_err;
   logic [CW-1:0]     w_err_n;
   logic [ADDR_W-1:0] r_fea;
   logic [DATA_W-1:0] r_fed;
   logic              r_pass;
   logic              w_rden;
   logic              w_go;
   logic              w_fin;
   logic              w_pv;
   logic [ADDR_W-1:0] w_pa;
   logic              w_mis;

   ram_rd_align #(
      .ADDR_W     (ADDR_W),
      .RD_LATENCY (RD_LATENCY)
   ) u_align (
      .clk     (clk_50M),
      .rst_n   (RST_N),
      .i_valid (w_rden),
      .i_addr  (r_addr),
      .o_valid (w_pv),
      .o_addr  (w_pa)
   );

   assign w_mis = w_pv && (ram.rddata != exp_word(w_pa, r_seed));

   // Saturate so a full-fault sweep can never wrap back to zero.
   assign w_err_n = (w_mis && r_err != ERR_MAX) ?
                    r_err + CW'(1) : r_err;

   always_comb begin
      w_state_n = r_state;
      w_addr_n  = r_addr;
      w_drain_n = r_drain;
      w_rden    = 1'b0;
      w_go      = 1'b0;
      w_fin     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_go      = 1'b1;
               w_addr_n  = '0;
               w_state_n = READ;
            end
         end
         READ: begin
            w_rden = 1'b1;
            if (r_addr == '1) begin
               w_drain_n = '0;
               w_state_n = DRAIN;
            end else begin
               w_addr_n = r_addr + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (r_drain == 3'(RD_LATENCY - 1)) begin
               w_fin     = 1'b1;
               w_state_n = DONE;
            end else begin
               w_drain_n = r_drain + 3'd1;
            end
         end
         DONE: begin
            w_state_n = IDLE;
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50M or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_drain <= '0;
         r_seed  <= '0;
         r_err   <= '0;
         r_fea   <= '0;
         r_fed   <= '0;
         r_pass  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_addr  <= w_addr_n;
         r_drain <= w_drain_n;
         if (w_go) begin
            r_seed <= seed;
            r_err  <= '0;
            r_fea  <= '0;
            r_fed  <= '0;
            r_pass <= 1'b0;
         end else begin
            r_err <= w_err_n;
            if (w_mis && r_err == '0) begin
               r_fea <= w_pa;
               r_fed <= ram.rddata;
            end
            // Last compare lands on this same edge, so judge w_err_n.
            if (w_fin) begin
               r_pass <= (w_err_n == '0);
            end
         end
      end
   end

   assign ram.address    = r_addr;
   assign ram.rden       = w_rden;
   assign busy           = (r_state != IDLE);
   assign done           = (r_state == DONE);
   assign pass           = r_pass;
   assign err_cnt        = r_err;
   assign first_err_addr = r_fea;
   assign first_err_data = r_fed;

endmodule

// File: doc/ram_readback_checker.md
# ram_readback_checker

Sequential read-back verifier for the 32×8 single-port test RAM. It sweeps every address in order and compares each `q` word against the expected counter pattern. It reports a pass/fail verdict, an error count and the first failing location. It sits beside the RAM write driver, drives the RAM's `address`/`rden` during its read phase, and consumes `q`.

## Interface
Parameters:
- `ADDR_W`, 5, RAM address width; depth = 2**ADDR_W.
- `DATA_W`, 8, RAM data width.
- `RD_LATENCY`, 1, clock cycles from `rden`/`address` sampled to valid `rddata` (registered `q`); legal 1..4.

Ports (one clock; reset is asynchronous and active-low):
- `clk_50M`  in  1  system clock, all logic on rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `seed`  in  DATA_W  pattern offset, sampled on accepted `start`.
- `address`  out  ADDR_W  RAM address.
- `rden`  out  1  RAM read enable.
- `rddata`  in  DATA_W  RAM `q`.
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle inclusive.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  verdict of the last completed sweep; valid from `done`, held until the next accepted `start`.
- `err_cnt`  out  ADDR_W+1  mismatches in the current or last sweep.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.
- `first_err_data`  out  DATA_W  data read at the first mismatch.

## Operation
- Expected word for address a: `(a + seed_q) mod 2**DATA_W`, where `seed_q` is the latched seed.
- FSM states:
  - IDLE: on `start`, latch the seed, clear `err_cnt`, `first_err_*` and `pass`, then go to READ.
  - READ: `rden`=1; `address` runs 0..DEPTH-1, one per cycle. After DEPTH−1 is issued, go to DRAIN.
  - DRAIN: `rden`=0; wait RD_LATENCY cycles, then go to DONE.
  - DONE: `done`=1 for one cycle; `pass` ← (`err_cnt`==0 including any final compare); return to IDLE.
- Compare: an issued-address pipeline (valid + address, depth RD_LATENCY) realigns each address with its `rddata`. The compare is performed only when the pipeline output is valid.
- On mismatch, `err_cnt` increments, saturating at 2**(ADDR_W+1)−1. On the first mismatch, `first_err_addr` and `first_err_data` are captured and never overwritten within the sweep.
- `start` while not IDLE is ignored. `start` in the DONE cycle is ignored.
- `address` holds its last value outside READ. `rden` is 0 outside READ.
- No write is ever issued. Arbitration of `address` against the write driver is the integrator's responsibility.

## Timing
- Reset values: `address`=0, `rden`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_addr`=0, `first_err_data`=0, FSM=IDLE, pipeline valids=0.
- `start` is sampled at edge 0:
  - `rden`=1 with `address`=k during cycle k+1, for k=0..DEPTH−1.
  - Data for address k is compared at edge k+1+RD_LATENCY.
  - `done` is high during cycle DEPTH+RD_LATENCY+1 (cycle 34 at defaults).
  - A new `start` is accepted from cycle DEPTH+RD_LATENCY+2.
- `err_cnt` updates the edge after the compare. It is final and stable when `done` is high.
- Reset asserted mid-sweep: all state is cleared immediately and asynchronously; `done` does not fire. A `start` after release begins a clean sweep.

## Structure
- Shared package `ram_test_pkg`: `ADDR_W`, `DATA_W`, `DEPTH` constants; FSM state enum (IDLE, READ, DRAIN, DONE); expected-pattern function `exp_word(addr, seed)`, also used by the write driver.
- Sub-module `ram_rd_align`: parameterised RD_LATENCY shift register of {valid, address}, with async reset, feeding the compare.

## Test plan
- Clean sweep: RAM preloaded with `mem[a]=a`, `seed`=0, one `start` → `rden` high cycles 1..32, `done` at cycle 34, `pass`=1, `err_cnt`=0.
- Single fault: `mem[5]=0xFF`, `seed`=0 → `pass`=0, `err_cnt`=1, `first_err_addr`=5, `first_err_data`=0xFF.
- Seed/wrap: `mem[a]=(a+0xF0)&0xFF`, `seed`=0xF0 → `pass`=1 (addresses 16..31 wrap to 0x00..0x0F).
- All-fault saturation: RAM all 0x00, `seed`=1 → `err_cnt`=32, `first_err_addr`=0.
- Latency sweep: repeat the clean sweep with RD_LATENCY=3 → `done` at cycle 36, `pass`=1; `start` pulsed at cycle 10 is ignored.
- Reset mid-sweep: assert `RST_N`=0 at cycle 15 → all outputs 0 immediately, no `done`. A fresh `start` after release → full 32-address sweep, correct verdict.
